// File: rtl/ad9910_ctrl_pkg.sv
// Shared types for the AD9910 serial-port scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, requester id, the latched transaction struct and
// the payload limits shared by the scheduler and its round-robin picker.
package ad9910_ctrl_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_IOUPD = 2'd3
  } sched_state_t;

  // Largest AD9910 register payload in bytes.
  localparam int MAX_BYTES = 8;

  // Storage widths of the transaction struct. The scheduler's DATA_WIDTH and
  // LEN_WIDTH parameters must not exceed these.
  localparam int TXN_DATA_W = 64;
  localparam int TXN_LEN_W  = 4;

  // Requester index: 0 = UART command decoder, 1 = timed-event sequencer.
  typedef logic req_id_t;

  // One register-write transaction as held between accept and completion.
  typedef struct packed {
    logic                  chip;   // 0 = DDS0 (csb), 1 = DDS1 (csb2)
    logic [7:0]            addr;   // instruction byte (R/W bit + address)
    logic [TXN_LEN_W-1:0]  len;    // payload bytes
    logic [TXN_DATA_W-1:0] data;   // payload, right-aligned
    logic                  ioupd;  // pulse IO_UPDATE after the frame
  } spi_txn_t;

endpackage

// File: rtl/ad9910_rr_pick.sv
// Two-way round-robin picker for the scheduler's requesters.
// Latency: purely combinational, grant in the same cycle as valid.
// Backpressure: none; the caller decides whether the grant is taken.
//
// Ports:
//   vld    in  2  per-requester valid
//   ptr    in  1  requester that wins when both are valid
//   grant  out 2  one-hot grant, all zero when nothing is valid
//   win_id out 1  index of the granted requester (0 when nothing is valid)
module ad9910_rr_pick
  import ad9910_ctrl_pkg::*;
(
  input  logic [1:0] vld,
  input  req_id_t    ptr,
  output logic [1:0] grant,
  output req_id_t    win_id
);

  always_comb begin
    win_id = 1'b0;
    grant  = 2'b00;
    if (vld[0] && vld[1]) begin
      // Contention: the priority pointer names the winner.
      win_id = ptr;
    end else if (vld[1]) begin
      win_id = 1'b1;
    end
    if (vld != 2'b00) begin
      grant = win_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ad9910_spi_scheduler.sv
// Shares one AD9910 serial-port engine between two requesters, round-robin.
// Latency: accept at edge k, eng_start in cycle k+1, WAIT from k+2.
// Backpressure: reqN_ready only in IDLE; requesters hold valid+payload until ready.
//
// Ports:
//   CLK100MHZ, RESET_N          clock, async active-low reset
//   reqN_valid/ready            per-requester handshake (N = 0, 1)
//   reqN_chip/addr/len/data     transaction payload, reqN_ioupd requests IO_UPDATE
//   eng_start                   one-cycle strobe to the SPI engine
//   eng_chip/addr/len/data      latched transaction, stable start..done
//   eng_done                    engine finished the frame (honoured in WAIT only)
//   io_update[chip]             IO_UPDATE pulse of IOUPD_CYCLES clocks
//   busy                        FSM not in IDLE
//   err_len                     one-cycle strobe: illegal length dropped
module ad9910_spi_scheduler
  import ad9910_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int LEN_WIDTH    = 4,
  parameter int IOUPD_CYCLES = 4
) (
  input  logic                  CLK100MHZ,
  input  logic                  RESET_N,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_chip,
  input  logic [7:0]            req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_ioupd,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_chip,
  input  logic [7:0]            req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_ioupd,

  output logic                  eng_start,
  output logic                  eng_chip,
  output logic [7:0]            eng_addr,
  output logic [LEN_WIDTH-1:0]  eng_len,
  output logic [DATA_WIDTH-1:0] eng_data,
  input  logic                  eng_done,

  output logic [1:0]            io_update,
  output logic                  busy,
  output logic                  err_len
);

  // Counter is loaded with IOUPD_CYCLES-1 so that the pulse spans exactly
  // IOUPD_CYCLES cycles including the cycle the counter reaches zero.
  localparam logic [3:0] IOUPD_LOAD = 4'(IOUPD_CYCLES - 1);

  sched_state_t state_q, state_d;
  spi_txn_t     txn_q;
  spi_txn_t     sel_txn;
  req_id_t      ptr_q;
  req_id_t      win_id;
  logic [1:0]   grant;
  logic [3:0]   ioupd_cnt_q;
  logic         err_len_q;
  logic         accept;
  logic         len_ok;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  ad9910_rr_pick u_pick (
    .vld    ({req1_valid, req0_valid}),
    .ptr    (ptr_q),
    .grant  (grant),
    .win_id (win_id)
  );

  // Payload of the current winner, widened to the struct's storage widths.
  always_comb begin
    sel_txn = '0;
    if (win_id == 1'b1) begin
      sel_txn.chip  = req1_chip;
      sel_txn.addr  = req1_addr;
      sel_txn.len   = TXN_LEN_W'(req1_len);
      sel_txn.data  = TXN_DATA_W'(req1_data);
      sel_txn.ioupd = req1_ioupd;
    end else begin
      sel_txn.chip  = req0_chip;
      sel_txn.addr  = req0_addr;
      sel_txn.len   = TXN_LEN_W'(req0_len);
      sel_txn.data  = TXN_DATA_W'(req0_data);
      sel_txn.ioupd = req0_ioupd;
    end
  end

  // Compared as int so the limit is not truncated by a narrow LEN_WIDTH.
  assign len_ok = (sel_txn.len != '0) && (int'(sel_txn.len) <= MAX_BYTES);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    eng_start = 1'b0;
    busy      = 1'b1;
    io_update = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (req0_valid || req1_valid) begin
          // Illegal lengths are still consumed so a bad requester cannot
          // stall the other one; they just never reach the engine.
          accept = 1'b1;
          if (len_ok) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d = txn_q.ioupd ? ST_IOUPD : ST_IDLE;
        end
      end
      ST_IOUPD: begin
        io_update = txn_q.chip ? 2'b10 : 2'b01;
        if (ioupd_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Only legal transactions overwrite the payload register, so eng_* keeps
  // showing the last frame actually sent to the engine.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      txn_q <= '0;
    end else if (accept && len_ok) begin
      txn_q <= sel_txn;
    end
  end

  // Priority goes to the requester that was not served, on every accept.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~win_id;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      err_len_q <= 1'b0;
    end else begin
      err_len_q <= accept && !len_ok;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      ioupd_cnt_q <= '0;
    end else if ((state_q == ST_WAIT) && (state_d == ST_IOUPD)) begin
      ioupd_cnt_q <= IOUPD_LOAD;
    end else if ((state_q == ST_IOUPD) && (ioupd_cnt_q != 4'd0)) begin
      ioupd_cnt_q <= ioupd_cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign eng_chip = txn_q.chip;
  assign eng_addr = txn_q.addr;
  assign eng_len  = txn_q.len[LEN_WIDTH-1:0];
  assign eng_data = txn_q.data[DATA_WIDTH-1:0];
  assign err_len  = err_len_q;

endmodule

// File: tb/tb_ad9910_spi_scheduler.sv
// Directed self-checking bench for ad9910_spi_scheduler (default parameters).
// Inputs change 2 ns after the rising edge; outputs are checked from there on.
module tb_ad9910_spi_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req0_valid = 1'b0, req0_ready, req0_chip = 1'b0, req0_ioupd = 1'b0;
  logic [7:0]  req0_addr = '0;
  logic [3:0]  req0_len = '0;
  logic [63:0] req0_data = '0;

  logic        req1_valid = 1'b0, req1_ready, req1_chip = 1'b0, req1_ioupd = 1'b0;
  logic [7:0]  req1_addr = '0;
  logic [3:0]  req1_len = '0;
  logic [63:0] req1_data = '0;

  logic        eng_start, eng_chip, eng_done = 1'b0;
  logic [7:0]  eng_addr;
  logic [3:0]  eng_len;
  logic [63:0] eng_data;
  logic [1:0]  io_update;
  logic        busy, err_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ad9910_spi_scheduler #(
    .DATA_WIDTH   (64),
    .LEN_WIDTH    (4),
    .IOUPD_CYCLES (4)
  ) dut (
    .CLK100MHZ  (clk),
    .RESET_N    (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_chip  (req0_chip),
    .req0_addr  (req0_addr),
    .req0_len   (req0_len),
    .req0_data  (req0_data),
    .req0_ioupd (req0_ioupd),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_chip  (req1_chip),
    .req1_addr  (req1_addr),
    .req1_len   (req1_len),
    .req1_data  (req1_data),
    .req1_ioupd (req1_ioupd),
    .eng_start  (eng_start),
    .eng_chip   (eng_chip),
    .eng_addr   (eng_addr),
    .eng_len    (eng_len),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .io_update  (io_update),
    .busy       (busy),
    .err_len    (err_len)
  );

  // Advance n rising edges, landing 2 ns after the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #23;
    if ({busy, eng_start, io_update, err_len, req0_ready, req1_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy, eng_start, io_update, err_len, req0_ready, req1_ready});
    end
    checks++;
    if ({eng_chip, eng_addr, eng_len, eng_data} !== 77'b0) begin
      errors++;
      $display("FAIL reset_payload: got addr=%h len=%h data=%h expected all 0",
               eng_addr, eng_len, eng_data);
    end
    checks++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_chip = 1'b0; req0_addr = 8'h0E; req0_len = 4'd8;
    req0_data = 64'h3FFF_0000_1999_999A; req0_ioupd = 1'b1;
    #1;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready});
    end
    checks++;
    step();  // accept edge; now in ISSUE
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready_drop: got %b expected 0", req0_ready);
    end
    checks++;
    req0_valid = 1'b0;
    req0_data  = 64'h0;
    if ({eng_start, eng_chip, eng_addr, eng_len, eng_data} !== {1'b1, 1'b0, 8'h0E, 4'd8, 64'h3FFF_0000_1999_999A}) begin
      errors++;
      $display("FAIL single_issue: got start=%b chip=%b addr=%h len=%h data=%h expected 1 0 0e 8 3fff000019999 99a",
               eng_start, eng_chip, eng_addr, eng_len, eng_data);
    end
    checks++;
    step();  // WAIT, start+1
    if ({eng_start, busy} !== 2'b01) begin
      errors++; $display("FAIL single_wait: got start,busy=%b expected 01", {eng_start, busy});
    end
    checks++;
    step(38);  // start+39
    if ({busy, io_update, eng_data} !== {1'b1, 2'b00, 64'h3FFF_0000_1999_999A}) begin
      errors++;
      $display("FAIL single_hold: got busy=%b iou=%b data=%h expected 1 00 3fff00001999999a",
               busy, io_update, eng_data);
    end
    checks++;
    step();  // start+40: engine reports done
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({io_update, busy} !== 3'b011) begin
        errors++; $display("FAIL single_ioupd[%0d]: got iou,busy=%b expected 011", i, {io_update, busy});
      end
      checks++;
      step();
    end
    if ({io_update, busy} !== 3'b000) begin
      errors++; $display("FAIL single_end: got iou,busy=%b expected 000", {io_update, busy});
    end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [63:0] d0, d1, exp_data;
    logic        exp_id;
    // Fresh reset so the priority pointer starts at requester 0.
    rst_n = 1'b0; #3; rst_n = 1'b1;
    step();
    d0 = 64'h0000_0000_A000_0000;
    d1 = 64'h0000_0000_0000_B000;
    req0_valid = 1'b1; req0_chip = 1'b0; req0_addr = 8'h01; req0_len = 4'd4; req0_data = d0; req0_ioupd = 1'b0;
    req1_valid = 1'b1; req1_chip = 1'b1; req1_addr = 8'h02; req1_len = 4'd2; req1_data = d1; req1_ioupd = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_id   = n[0];
      exp_data = exp_id ? d1 : d0;
      #1;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got ready=%b expected %b", n, {req1_ready, req0_ready},
                 exp_id ? 2'b10 : 2'b01);
      end
      checks++;
      step();
      // New payload after the accept edge: the frame must show the old one.
      if (exp_id) begin d1 = d1 + 64'd1; req1_data = d1; end
      else        begin d0 = d0 + 64'd1; req0_data = d0; end
      if ({eng_start, eng_chip, eng_addr, eng_data} !== {1'b1, exp_id, (exp_id ? 8'h02 : 8'h01), exp_data}) begin
        errors++;
        $display("FAIL rr_frame[%0d]: got start=%b chip=%b addr=%h data=%h expected 1 %b %h %h",
                 n, eng_start, eng_chip, eng_addr, eng_data, exp_id, exp_id ? 8'h02 : 8'h01, exp_data);
      end
      checks++;
      step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      if (exp_id) begin
        for (int i = 0; i < 4; i++) begin
          if (io_update !== 2'b10) begin
            errors++; $display("FAIL rr_ioupd[%0d.%0d]: got %b expected 10", n, i, io_update);
          end
          checks++;
          step();
        end
      end
      if (busy !== 1'b0) begin
        errors++; $display("FAIL rr_idle[%0d]: got busy=%b expected 0", n, busy);
      end
      checks++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_err_len();
    // Pointer is at requester 0 here; req1 alone still wins.
    req1_valid = 1'b1; req1_chip = 1'b1; req1_addr = 8'h0E; req1_len = 4'd0; req1_ioupd = 1'b1;
    #1;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL err_accept: got ready=%b expected 10", {req1_ready, req0_ready});
    end
    checks++;
    step();  // k+1
    if ({err_len, eng_start, busy, io_update} !== 5'b10000) begin
      errors++;
      $display("FAIL err_pulse: got err,start,busy,iou=%b expected 10000", {err_len, eng_start, busy, io_update});
    end
    checks++;
    req1_len = 4'd2; req1_ioupd = 1'b0; req1_data = 64'h0000_0000_0000_C3C3;
    req0_valid = 1'b1; req0_chip = 1'b0; req0_addr = 8'h07; req0_len = 4'd1;
    req0_data = 64'h0000_0000_0000_005A; req0_ioupd = 1'b0;
    #1;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL err_next_grant: got ready=%b expected 01", {req1_ready, req0_ready});
    end
    checks++;
    step();
    req0_valid = 1'b0;
    if ({err_len, eng_start, eng_chip, eng_addr} !== {1'b0, 1'b1, 1'b0, 8'h07}) begin
      errors++;
      $display("FAIL err_req0_frame: got err=%b start=%b chip=%b addr=%h expected 0 1 0 07",
               err_len, eng_start, eng_chip, eng_addr);
    end
    checks++;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    #1;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL err_req1_grant: got ready=%b expected 10", {req1_ready, req0_ready});
    end
    checks++;
    step();
    req1_valid = 1'b0;
    if ({eng_start, eng_chip, eng_len, eng_data} !== {1'b1, 1'b1, 4'd2, 64'h0000_0000_0000_C3C3}) begin
      errors++;
      $display("FAIL err_req1_frame: got start=%b chip=%b len=%h data=%h expected 1 1 2 c3c3",
               eng_start, eng_chip, eng_len, eng_data);
    end
    checks++;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    // Length 9 is also illegal.
    req0_valid = 1'b1; req0_len = 4'd9;
    step();
    req0_valid = 1'b0;
    if ({err_len, eng_start, busy} !== 3'b100) begin
      errors++; $display("FAIL err_len9: got err,start,busy=%b expected 100", {err_len, eng_start, busy});
    end
    checks++;
    step();
    if ({err_len, eng_start} !== 2'b00) begin
      errors++; $display("FAIL err_one_cycle: got err,start=%b expected 00", {err_len, eng_start});
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_start;
    exp_start = 6'b100100;  // bit 5 = first cycle after the first accept
    req0_valid = 1'b1; req0_len = 4'd3; req0_ioupd = 1'b0;
    eng_done = 1'b1;  // engine completes instantly; ignored outside WAIT
    for (int i = 0; i < 6; i++) begin
      step();
      if (eng_start !== exp_start[5-i]) begin
        errors++; $display("FAIL b2b_start[%0d]: got %b expected %b", i, eng_start, exp_start[5-i]);
      end
      checks++;
    end
    req0_valid = 1'b0;
    eng_done = 1'b0;
    step();
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy);
    end
    checks++;
  endtask

  task automatic test_done_in_issue();
    req0_valid = 1'b1; req0_len = 4'd2; req0_ioupd = 1'b0;
    step();  // cycle c: ISSUE
    req0_valid = 1'b0;
    eng_done = 1'b1;
    step();  // c+1
    eng_done = 1'b0;
    if ({busy, eng_start} !== 2'b10) begin
      errors++; $display("FAIL issue_done_ignored: got busy,start=%b expected 10", {busy, eng_start});
    end
    checks++;
    step(9);  // c+10
    if (busy !== 1'b1) begin
      errors++; $display("FAIL issue_still_wait: got busy=%b expected 1", busy);
    end
    checks++;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL issue_second_done: got busy=%b expected 0", busy);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_chip = 1'b0; req0_len = 4'd8; req0_ioupd = 1'b1;
    req0_data = 64'hDEAD_BEEF_0000_0001;
    step();
    req0_valid = 1'b0;
    step(3);  // WAIT
    #2; rst_n = 1'b0; #1;
    if ({busy, eng_start, io_update, err_len, eng_addr, eng_data} !== 77'b0) begin
      errors++;
      $display("FAIL rst_wait: got busy=%b start=%b iou=%b addr=%h data=%h expected all 0",
               busy, eng_start, io_update, eng_addr, eng_data);
    end
    checks++;
    #2; rst_n = 1'b1;
    step();
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();  // second IOUPD cycle
    if (io_update !== 2'b01) begin
      errors++; $display("FAIL rst_pre_ioupd: got %b expected 01", io_update);
    end
    checks++;
    #2; rst_n = 1'b0; #1;
    if ({io_update, busy, eng_data} !== 67'b0) begin
      errors++;
      $display("FAIL rst_ioupd: got iou=%b busy=%b data=%h expected all 0", io_update, busy, eng_data);
    end
    checks++;
    #2; rst_n = 1'b1;
    step();
    // Requester 0 was served last, but reset returns priority to it.
    req0_valid = 1'b1; req0_ioupd = 1'b0;
    req1_valid = 1'b1; req1_len = 4'd1;
    #1;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_priority: got ready=%b expected 01", {req1_ready, req0_ready});
    end
    checks++;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_err_len();
    test_back_to_back();
    test_done_in_issue();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9910_spi_scheduler.md
# ad9910_spi_scheduler

Shares the single AD9910 serial-port engine (common SCLK, per-chip CSB/SDIO) between two command requesters: the UART command decoder and the timed-event sequencer. Arbitrates round-robin, latches one register-write transaction at a time, and issues it to the engine. After completion it optionally pulses IO_UPDATE on the addressed DDS. Sits between the command sources and the AD9910 SPI driver inside `main`.

## Interface
Parameters:
- `DATA_WIDTH`, 64: maximum payload width in bits (AD9910 largest register = 8 bytes).
- `LEN_WIDTH`, 4: byte-count width.
- `IOUPD_CYCLES`, 4: IO_UPDATE pulse length in clocks (1..15).

Ports (`N` = 0, 1):
- `CLK100MHZ`  in  1  system clock, 100 MHz; the only clock.
- `RESET_N`  in  1  reset, asynchronous assert, active-low.
- `reqN_valid`  in  1  requester N has a transaction.
- `reqN_ready`  out  1  transaction accepted this cycle.
- `reqN_chip`  in  1  target DDS: 0 = DDS0 (csb), 1 = DDS1 (csb2).
- `reqN_addr`  in  8  AD9910 instruction byte (R/W bit + address).
- `reqN_len`  in  LEN_WIDTH  payload bytes, legal 1..8.
- `reqN_data`  in  DATA_WIDTH  payload, right-aligned (low len*8 bits, MSB-first on wire).
- `reqN_ioupd`  in  1  pulse IO_UPDATE after the write.
- `eng_start`  out  1  one-cycle start strobe to the SPI engine.
- `eng_chip`, `eng_addr`, `eng_len`, `eng_data`  out  1/8/LEN_WIDTH/DATA_WIDTH  latched transaction, stable from `eng_start` until `eng_done`.
- `eng_done`  in  1  one-cycle strobe: engine has finished the frame and released CSB.
- `io_update`  out  2  per-chip IO_UPDATE, bit index = chip.
- `busy`  out  1  high in any state except IDLE.
- `err_len`  out  1  one-cycle strobe: illegal length dropped.

## Operation
- FSM states: IDLE, ISSUE, WAIT, IOUPD.
- IDLE: if any `reqN_valid`, the round-robin picker selects one. The selected `reqN_ready` is high combinationally in the same cycle. Payload is latched on that edge.
- Round-robin: with both valid, the requester not granted last wins. The priority pointer resets to requester 0, and updates only on an accept.
- Legal length accepted: go to ISSUE.
- Illegal length (0 or >8): still accepted (ready high), `err_len` pulses next cycle, no engine frame, no IO_UPDATE; stay IDLE. The pointer still advances.
- ISSUE: `eng_start`=1 for exactly one cycle, then WAIT.
- WAIT: hold latched outputs until `eng_done`. Then go to IOUPD if the latched ioupd=1, else IDLE.
- IOUPD: `io_update[chip]`=1 for IOUPD_CYCLES cycles (down-counter), then IDLE. The other bit stays 0.
- `eng_done` outside WAIT (including in the ISSUE cycle) is ignored.
- `reqN_ready` is 0 in every state except IDLE. Requesters must hold valid and payload until ready.
- Reset (any time, including mid-frame): state IDLE, all outputs 0, `eng_*` payload 0, counter 0, pointer 0. The engine is reset by the same `RESET_N`.

## Timing
- Accept at edge k; `eng_start` high in cycle k+1; WAIT from k+2.
- `eng_done` seen in cycle d: `io_update` high in cycles d+1 .. d+IOUPD_CYCLES, `busy` low from d+IOUPD_CYCLES+1.
- Without IO_UPDATE: `busy` low from d+1; the next accept is possible in cycle d+1.
- Back-to-back requests: minimum 3-cycle gap between `eng_start` strobes (accept, issue, done) when the engine completes instantly.
- `err_len` is high in cycle k+1 only.

## Structure
- Package `ad9910_ctrl_pkg`:
  - state enum `sched_state_t`
  - `MAX_BYTES` = 8
  - `req_id_t` (1 bit)
  - transaction struct `spi_txn_t` (chip, addr, len, data, ioupd)
- Sub-module `ad9910_rr_pick`: 2-way round-robin picker. Inputs: valids, pointer. Outputs: grant one-hot, winner id.
- Top module holds the FSM, payload register, IO_UPDATE counter and pointer.

## Test plan
- Req0 only (chip 0, addr 0x0E, len 8, data 0x3FFF_0000_1999_999A, ioupd 1):
  - ready for 1 cycle; `eng_start` next cycle with identical payload
  - engine done 40 cycles later gives `io_update`=2'b01 for 4 cycles, then `busy`=0.
- Both valid continuously, 4 transactions each:
  - grants alternate 0,1,0,1,…
  - req1 (chip 1) produces frames with `eng_chip`=1 and `io_update`=2'b10.
- Req1 len 0:
  - accepted, `err_len` pulse, no `eng_start`
  - then req0 pending is granted next IDLE cycle.
- `eng_done` asserted in the ISSUE cycle and again 10 cycles later: FSM leaves WAIT only on the second.
- `RESET_N` low mid-WAIT and mid-IOUPD: all outputs 0 immediately (async). After release, req1 and req0 both valid grants req0 first.
